// File: rtl/get_velocity_pkg.sv
// Shared defaults and FSM state encoding for the vertical-velocity burn model.
package get_velocity_pkg;

  localparam int unsigned DEF_N            = 64;
  localparam int unsigned DEF_GRAVITY      = 9799;
  localparam int unsigned DEF_CLKS_PER_SEC = 50000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_BURN = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/get_velocity_seq_divider.sv
// N-bit unsigned restoring divider, one quotient bit per cycle.
// start_i loads the operands; done_o pulses for one cycle when quotient_o is valid.
// A zero divisor finishes on the next cycle with a zero quotient.
module seq_divider
  import get_velocity_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         done_o,
  output logic [N-1:0] quotient_o
);

  localparam int unsigned CW = $clog2(N + 1);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N:0]    shifted_c;
  logic [N:0]    trial_c;

  // Partial remainder shifted by one dividend bit and the trial subtraction.
  assign shifted_c = {rem_q, quo_q[N-1]};
  assign trial_c   = shifted_c - {1'b0, dvs_q};

  // Divider state register.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  // Operand load on start, otherwise one restoring step per cycle while busy.
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    if (start_i) begin
      rem_d = '0;
      if (divisor_i == '0) begin
        quo_d  = '0;
        busy_d = 1'b0;
        done_d = 1'b1;
      end else begin
        quo_d  = dividend_i;
        dvs_d  = divisor_i;
        cnt_d  = CW'(N);
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      if (!trial_c[N]) begin
        rem_d = trial_c[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b1};
      end else begin
        rem_d = shifted_c[N-1:0];
        quo_d = {quo_q[N-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q;

endmodule

// File: rtl/get_velocity.sv
// Rocket-burn vertical velocity integrator.
// Once per simulated second the thrust acceleration K/m is recomputed with the
// shared sequential divider and folded into the velocity together with gravity.
// The thrust for the second that just ended uses the mass at the start of that
// second; afterWeight reports the mass at its end.
module get_velocity
  import get_velocity_pkg::*;
#(
  parameter int unsigned N            = DEF_N,
  parameter int unsigned GRAVITY      = DEF_GRAVITY,
  parameter int unsigned CLKS_PER_SEC = DEF_CLKS_PER_SEC
) (
  input  logic         CLK,
  input  logic         RESETB,
  input  logic [N-1:0] specificImpulse,
  input  logic [N-1:0] initialWeight,
  input  logic [N-1:0] propellantWeight,
  input  logic [N-1:0] burntime,
  input  logic         backward,
  output logic [N-1:0] velocity,
  output logic [N-1:0] afterWeight,
  output logic         ignition_end
);

  localparam int unsigned   CW       = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_SEC - 1);
  localparam logic [N-1:0]  G_UM     = N'(GRAVITY * 1000);

  state_e        state_q, state_d;
  logic [N-1:0]  isp_q, isp_d;
  logic [N-1:0]  m0_q, m0_d;
  logic [N-1:0]  prop_q, prop_d;
  logic [N-1:0]  bt_q, bt_d;
  logic          back_q, back_d;
  logic [N-1:0]  mdot_q, mdot_d;
  logic [N-1:0]  k_q, k_d;
  logic [N-1:0]  t_q, t_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          thr_zero_q, thr_zero_d;
  logic [N-1:0]  vel_q, vel_d;
  logic [N-1:0]  aw_q, aw_d;
  logic          end_q, end_d;

  logic          div_start_c;
  logic [N-1:0]  div_dividend_c;
  logic [N-1:0]  div_divisor_c;
  logic          div_done;
  logic [N-1:0]  div_quo;

  logic [N-1:0]  m_cur_c;
  logic [N-1:0]  k_c;
  logic [N-1:0]  a_thr_c;
  logic [N-1:0]  vel_fwd_c;
  logic [N-1:0]  vel_sub_c;
  logic [N-1:0]  vel_upd_c;
  logic          cnt_last_c;

  // Single divider shared by the mass-flow and thrust-acceleration divisions.
  seq_divider #(.N(N)) u_div (
    .CLK        (CLK),
    .RESETB     (RESETB),
    .start_i    (div_start_c),
    .dividend_i (div_dividend_c),
    .divisor_i  (div_divisor_c),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  // Datapath: current mass, thrust constant, and saturating velocity update.
  assign m_cur_c    = m0_q - mdot_q * t_q;
  assign k_c        = isp_q * G_UM * div_quo;
  assign a_thr_c    = thr_zero_q ? '0 : div_quo;
  assign vel_fwd_c  = vel_q + a_thr_c;
  assign vel_sub_c  = a_thr_c + G_UM;
  assign vel_upd_c  = back_q ? ((vel_q < vel_sub_c) ? '0 : vel_q - vel_sub_c)
                             : ((vel_fwd_c < G_UM) ? '0 : vel_fwd_c - G_UM);
  assign cnt_last_c = (cnt_q == CNT_LAST);

  // State and datapath registers; reset clears every burn-related value.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      state_q    <= ST_IDLE;
      isp_q      <= '0;
      m0_q       <= '0;
      prop_q     <= '0;
      bt_q       <= '0;
      back_q     <= 1'b0;
      mdot_q     <= '0;
      k_q        <= '0;
      t_q        <= '0;
      cnt_q      <= '0;
      thr_zero_q <= 1'b0;
      vel_q      <= '0;
      aw_q       <= '0;
      end_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      isp_q      <= isp_d;
      m0_q       <= m0_d;
      prop_q     <= prop_d;
      bt_q       <= bt_d;
      back_q     <= back_d;
      mdot_q     <= mdot_d;
      k_q        <= k_d;
      t_q        <= t_d;
      cnt_q      <= cnt_d;
      thr_zero_q <= thr_zero_d;
      vel_q      <= vel_d;
      aw_q       <= aw_d;
      end_q      <= end_d;
    end
  end

  // Next-state and register-update logic for the burn sequence.
  always_comb begin
    state_d        = state_q;
    isp_d          = isp_q;
    m0_d           = m0_q;
    prop_d         = prop_q;
    bt_d           = bt_q;
    back_d         = back_q;
    mdot_d         = mdot_q;
    k_d            = k_q;
    t_d            = t_q;
    cnt_d          = cnt_q;
    thr_zero_d     = thr_zero_q;
    vel_d          = vel_q;
    aw_d           = aw_q;
    end_d          = end_q;
    div_start_c    = 1'b0;
    div_dividend_c = '0;
    div_divisor_c  = '0;

    case (state_q)
      ST_IDLE: begin
        // Inputs are captured once here and ignored until the next reset.
        isp_d          = specificImpulse;
        m0_d           = initialWeight;
        prop_d         = propellantWeight;
        bt_d           = burntime;
        back_d         = backward;
        aw_d           = initialWeight;
        div_start_c    = 1'b1;
        div_dividend_c = propellantWeight;
        div_divisor_c  = burntime;
        state_d        = ST_LOAD;
      end

      ST_LOAD: begin
        if (bt_q == '0) begin
          aw_d    = m0_q - prop_q;
          end_d   = 1'b1;
          state_d = ST_DONE;
        end else if (div_done) begin
          mdot_d  = div_quo;
          k_d     = k_c;
          t_d     = '0;
          cnt_d   = '0;
          state_d = ST_BURN;
        end
      end

      ST_BURN: begin
        cnt_d = cnt_last_c ? '0 : cnt_q + CW'(1);
        if (cnt_last_c) begin
          // Second tick: divide by the mass at the start of the elapsed second.
          t_d            = t_q + N'(1);
          thr_zero_d     = (m_cur_c == '0) || (m_cur_c > m0_q);
          div_start_c    = 1'b1;
          div_dividend_c = k_q;
          div_divisor_c  = m_cur_c;
          state_d        = ST_DIV;
        end
      end

      ST_DIV: begin
        // Second counter keeps running so ticks stay one second apart.
        cnt_d = cnt_last_c ? '0 : cnt_q + CW'(1);
        if (div_done) begin
          vel_d = vel_upd_c;
          if (t_q == bt_q) begin
            aw_d    = m0_q - prop_q;
            end_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            aw_d    = m_cur_c;
            state_d = ST_BURN;
          end
        end
      end

      ST_DONE: begin
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign velocity     = vel_q;
  assign afterWeight  = aw_q;
  assign ignition_end = end_q;

endmodule

// File: tb/tb_get_velocity.sv
// Directed bench for get_velocity with CLKS_PER_SEC = 100.
module tb_get_velocity;

  localparam int unsigned CPS  = 100;
  localparam logic [63:0] G_UM = 64'd9799000;

  typedef struct {
    logic [63:0] isp;
    logic [63:0] m0;
    logic [63:0] prop;
    logic [63:0] bt;
    logic        back;
    logic [63:0] exp_v1;
    logic [63:0] exp_aw1;
    logic [63:0] exp_awf;
  } vec_t;

  logic        CLK;
  logic        RESETB;
  logic [63:0] isp, m0, prop, bt;
  logic        back;
  logic [63:0] velocity, after_w;
  logic        ign;

  int checks = 0;
  int errors = 0;

  vec_t vecs [7];

  get_velocity #(.N(64), .GRAVITY(9799), .CLKS_PER_SEC(CPS)) dut (
    .CLK              (CLK),
    .RESETB           (RESETB),
    .specificImpulse  (isp),
    .initialWeight    (m0),
    .propellantWeight (prop),
    .burntime         (bt),
    .backward         (back),
    .velocity         (velocity),
    .afterWeight      (after_w),
    .ignition_end     (ign)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference integration: thrust over second t uses mass m0 - mdot*(t-1).
  function automatic logic [63:0] model_vel(input vec_t v);
    logic [63:0] mdot, k, mp, a, s, vel;
    vel = 64'd0;
    if (v.bt == 64'd0) return vel;
    mdot = v.prop / v.bt;
    k    = v.isp * G_UM * mdot;
    for (longint unsigned t = 1; t <= v.bt; t++) begin
      mp = v.m0 - mdot * (t - 1);
      a  = (mp == 64'd0 || mp > v.m0) ? 64'd0 : k / mp;
      if (v.back) begin
        s   = a + G_UM;
        vel = (vel < s) ? 64'd0 : vel - s;
      end else begin
        s   = vel + a;
        vel = (s < G_UM) ? 64'd0 : s - G_UM;
      end
    end
    return vel;
  endfunction

  // Reset with new inputs, release, and check the first-second update.
  task automatic start_burn(input vec_t v, input string tag);
    int n;
    @(negedge CLK);
    RESETB = 1'b0;
    isp = v.isp; m0 = v.m0; prop = v.prop; bt = v.bt; back = v.back;
    repeat (2) @(negedge CLK);
    check({tag, "_rst_vel"}, velocity, 64'd0);
    check({tag, "_rst_aw"}, after_w, 64'd0);
    check({tag, "_rst_ign"}, 64'(ign), 64'd0);
    RESETB = 1'b1;
    if (v.bt == 64'd0) begin
      n = 0;
      while (!ign && n < 3) begin
        @(negedge CLK);
        n++;
      end
      check({tag, "_ign_within3"}, 64'(ign), 64'd1);
      return;
    end
    repeat (2) @(negedge CLK);
    check({tag, "_load_aw"}, after_w, v.m0);
    n = 0;
    while (after_w == v.m0 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_tick1_seen"}, 64'(n < 400), 64'd1);
    check({tag, "_tick1_vel"}, velocity, v.exp_v1);
    check({tag, "_tick1_aw"}, after_w, v.exp_aw1);
    check({tag, "_tick1_ign"}, 64'(ign), 64'd0);
  endtask

  // Wait for the end of the burn and check final and held values.
  task automatic finish_burn(input vec_t v, input string tag, input int hold);
    int n, budget;
    logic [63:0] exp_v;
    exp_v  = model_vel(v);
    budget = int'(v.bt) * (CPS + 70) + 400;
    n = 0;
    while (!ign && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_end_ign"}, 64'(ign), 64'd1);
    check({tag, "_end_vel"}, velocity, exp_v);
    check({tag, "_end_aw"}, after_w, v.exp_awf);
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      check({tag, "_hold_vel"}, velocity, exp_v);
      check({tag, "_hold_aw"}, after_w, v.exp_awf);
      check({tag, "_hold_ign"}, 64'(ign), 64'd1);
    end
  endtask

  initial begin
    vec_t v0;
    int   n;

    //         isp       m0             prop       bt     back  v1              aw1            awf
    vecs[0] = '{64'd363, 64'd2875403, 64'd2077000, 64'd48, 1'b0, 64'd43728450,  64'd2832133, 64'd798403};
    vecs[1] = '{64'd1,   64'd1000000, 64'd1000,    64'd10, 1'b0, 64'd0,         64'd999900,  64'd999000};
    vecs[2] = '{64'd363, 64'd2875403, 64'd129810,  64'd3,  1'b1, 64'd0,         64'd2832133, 64'd2745593};
    vecs[3] = '{64'd300, 64'd1000,    64'd500,     64'd5,  1'b0, 64'd284171000, 64'd900,     64'd500};
    vecs[4] = '{64'd300, 64'd5000,    64'd1234,    64'd0,  1'b0, 64'd0,         64'd0,       64'd3766};
    vecs[5] = '{64'd2,   64'd2000,    64'd1009,    64'd10, 1'b0, 64'd0,         64'd1900,    64'd991};
    vecs[6] = '{64'd1,   64'd100,     64'd300,     64'd3,  1'b0, 64'd0,         64'd0,       64'hFFFF_FFFF_FFFF_FF38};

    RESETB = 1'b0;
    isp = '0; m0 = '0; prop = '0; bt = '0; back = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 7; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_burn(vecs[i], tag);
      finish_burn(vecs[i], tag, (i == 0) ? 500 : 20);
    end

    // Asynchronous reset in the middle of the tick-5 divide, then a clean restart.
    v0 = vecs[0];
    start_burn(v0, "midrst");
    for (int k = 2; k <= 4; k++) begin
      logic [63:0] prev;
      prev = after_w;
      n = 0;
      while (after_w == prev && n < 300) begin
        @(negedge CLK);
        n++;
      end
      check($sformatf("midrst_tick%0d_aw", k), after_w, v0.m0 - 64'd43270 * 64'(k));
    end
    repeat (60) @(negedge CLK);
    @(posedge CLK);
    #2 RESETB = 1'b0;
    #1;
    check("midrst_async_vel", velocity, 64'd0);
    check("midrst_async_aw", after_w, 64'd0);
    check("midrst_async_ign", 64'(ign), 64'd0);
    start_burn(v0, "restart");

    // Inputs changed mid-burn must not disturb the latched burn.
    isp = 64'd1; m0 = 64'd5; prop = 64'd7; bt = 64'd2; back = 1'b1;
    finish_burn(v0, "inchg", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
